param_memory_bank: RTL and testbench

PARAM_MEMORY_BANK -- requirements
Module: param_memory_bank

---
 rtl/param_memory_bank.sv | 112 +++++++++++
 tb/tb_param_memory_bank.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/param_memory_bank.sv
// -----------------------------------------------------------------------------
// param_memory_bank
//   DEPTH x WIDTH register-array memory. It has one shared write/read address
//   and a one-cycle registered read. Reads return the contents as they were
//   before the current edge (read-before-write). A two-state FSM can zero every
//   entry in exactly DEPTH cycles.
//
// Ports
//   clk    : single clock, all state changes on the rising edge
//   reset  : asynchronous, active-high; clears storage, outputs, FSM, pointer
//   data   : write data (WIDTH)
//   store  : write strobe, honoured only in IDLE and only for addr < DEPTH
//   addr   : shared write/read address (ADDR_W)
//   clear  : request to start a bulk clear, honoured only in IDLE
//   memory : registered read data for addr, or 0 if addr >= DEPTH
//   busy   : high while the clear sequence runs
//   done   : one-cycle pulse after the final clear write
// -----------------------------------------------------------------------------
module param_memory_bank #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  data,
    input  logic              store,
    input  logic [ADDR_W-1:0] addr,
    input  logic              clear,
    output logic [WIDTH-1:0]  memory,
    output logic              busy,
    output logic              done
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // The pointer is one bit wider than the address, so a DEPTH that is a
    // power of two cannot wrap back to zero before the sequence ends.
    localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'(DEPTH - 1);

    state_t            state_r;
    logic [ADDR_W:0]   ptr_r;
    logic [WIDTH-1:0]  mem_r [DEPTH];
    logic              addr_ok_s;

    // Address range check shared by the write and read paths
    assign addr_ok_s = ({1'b0, addr} < DEPTH_W);

    // Storage, registered read port and clear FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            memory  <= {WIDTH{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            state_r <= IDLE;
            ptr_r   <= {(ADDR_W + 1){1'b0}};
        end else begin
            // The read uses the pre-edge array contents in both states. The
            // non-blocking writes below land only after this sample.
            if (addr_ok_s) begin
                memory <= mem_r[addr];
            end else begin
                memory <= {WIDTH{1'b0}};
            end

            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (clear) begin
                        // A clear request takes priority over a write in the same cycle.
                        state_r <= CLEAR;
                        ptr_r   <= {(ADDR_W + 1){1'b0}};
                        busy    <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                        if (store && addr_ok_s) begin
                            mem_r[addr] <= data;
                        end
                    end
                end

                CLEAR: begin
                    // store and clear are ignored until the sequence finishes.
                    mem_r[ptr_r[ADDR_W-1:0]] <= {WIDTH{1'b0}};
                    ptr_r <= ptr_r + (ADDR_W + 1)'(1);
                    if (ptr_r == LAST_PTR) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        busy <= 1'b1;
                        done <= 1'b0;
                    end
                end

                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_memory_bank.sv
// -----------------------------------------------------------------------------
// tb_param_memory_bank
//   Directed bench for param_memory_bank with its default parameters
//   (WIDTH=8, DEPTH=4). Inputs change 1 time unit after a rising edge. Outputs
//   are checked at that same point, which is away from the active edge.
// -----------------------------------------------------------------------------
module tb_param_memory_bank;

    logic       clk;
    logic       reset;
    logic [7:0] data;
    logic       store;
    logic [1:0] addr;
    logic       clear;
    logic [7:0] memory;
    logic       busy;
    logic       done;

    int n_vec;
    int n_err;

    param_memory_bank #(
        .WIDTH (8),
        .DEPTH (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .data   (data),
        .store  (store),
        .addr   (addr),
        .clear  (clear),
        .memory (memory),
        .busy   (busy),
        .done   (done)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [1:0] a, input logic [7:0] d);
        store = 1'b1;
        addr  = a;
        data  = d;
        tick();
        store = 1'b0;
    endtask

    // Directed stimulus
    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        data  = 8'h00;
        store = 1'b0;
        addr  = 2'd0;
        clear = 1'b0;

        // Asynchronous reset, checked before any clock edge
        #2 reset = 1'b1;
        #1;
        check_eq("rst_memory", {24'd0, memory}, 32'h0);
        check_eq("rst_busy", {31'd0, busy}, 32'h0);
        check_eq("rst_done", {31'd0, done}, 32'h0);
        tick();
        reset = 1'b0;

        // Reset then read every address
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            tick();
            check_eq($sformatf("rd_after_rst_%0d", a), {24'd0, memory}, 32'h0);
        end
        check_eq("idle_busy", {31'd0, busy}, 32'h0);
        check_eq("idle_done", {31'd0, done}, 32'h0);

        // Write/read
        write_word(2'd2, 8'hA5);
        write_word(2'd1, 8'h3C);
        addr = 2'd2;
        tick();
        check_eq("rd_addr2", {24'd0, memory}, 32'hA5);
        addr = 2'd1;
        tick();
        check_eq("rd_addr1", {24'd0, memory}, 32'h3C);

        // Read-before-write on a held address
        write_word(2'd3, 8'h11);
        store = 1'b1;
        data  = 8'h22;
        tick();
        store = 1'b0;
        check_eq("rbw_old", {24'd0, memory}, 32'h11);
        tick();
        check_eq("rbw_new", {24'd0, memory}, 32'h22);

        // Bulk clear, with a store lost mid-sequence and a restart on done
        for (int a = 0; a < 4; a++) write_word(2'(a), 8'hFF);
        clear = 1'b1;
        tick();                                    // E0: enter CLEAR
        clear = 1'b0;
        check_eq("clr_busy_e0", {31'd0, busy}, 32'h1);
        check_eq("clr_done_e0", {31'd0, done}, 32'h0);
        tick();                                    // E1: entry 0 zeroed
        check_eq("clr_busy_e1", {31'd0, busy}, 32'h1);
        store = 1'b1;
        addr  = 2'd0;
        data  = 8'h55;
        clear = 1'b1;                              // ignored while busy
        tick();                                    // E2
        store = 1'b0;
        clear = 1'b0;
        check_eq("clr_busy_e2", {31'd0, busy}, 32'h1);
        tick();                                    // E3
        check_eq("clr_busy_e3", {31'd0, busy}, 32'h1);
        check_eq("clr_done_e3", {31'd0, done}, 32'h0);
        tick();                                    // E4: last entry zeroed
        check_eq("clr_busy_e4", {31'd0, busy}, 32'h0);
        check_eq("clr_done_e4", {31'd0, done}, 32'h1);
        clear = 1'b1;                              // request during done restarts
        tick();
        clear = 1'b0;
        check_eq("restart_done", {31'd0, done}, 32'h0);
        check_eq("restart_busy", {31'd0, busy}, 32'h1);
        for (int c = 0; c < 3; c++) tick();
        check_eq("restart_busy_end", {31'd0, busy}, 32'h1);
        tick();
        check_eq("restart_done_end", {31'd0, done}, 32'h1);
        tick();
        check_eq("restart_done_low", {31'd0, done}, 32'h0);
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            tick();
            check_eq($sformatf("rd_after_clr_%0d", a), {24'd0, memory}, 32'h0);
        end

        // Clear and store together: the write is dropped
        write_word(2'd0, 8'h44);
        addr  = 2'd0;
        clear = 1'b1;
        store = 1'b1;
        data  = 8'h77;
        tick();                                    // E0
        clear = 1'b0;
        store = 1'b0;
        check_eq("sim_busy", {31'd0, busy}, 32'h1);
        tick();                                    // E1: pre-edge entry 0
        check_eq("sim_entry0_kept", {24'd0, memory}, 32'h44);
        tick();                                    // E2: entry 0 zeroed at E1
        check_eq("sim_entry0_zero", {24'd0, memory}, 32'h0);
        for (int c = 0; c < 3; c++) tick();
        check_eq("sim_idle_busy", {31'd0, busy}, 32'h0);

        // Reset during cycle 2 of a clear
        for (int a = 0; a < 4; a++) write_word(2'(a), 8'h5A);
        clear = 1'b1;
        tick();                                    // E0
        clear = 1'b0;
        tick();                                    // E1
        tick();                                    // E2
        #2 reset = 1'b1;
        #1;
        check_eq("midrst_busy", {31'd0, busy}, 32'h0);
        check_eq("midrst_done", {31'd0, done}, 32'h0);
        check_eq("midrst_memory", {24'd0, memory}, 32'h0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq($sformatf("midrst_nodone_%0d", c), {31'd0, done}, 32'h0);
        end
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            tick();
            check_eq($sformatf("rd_after_midrst_%0d", a), {24'd0, memory}, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
